// File: rtl/alu_pkg.sv
// Shared opcode, unit-index and state definitions for the bitwise ALU datapath.
package alu_pkg;

  localparam int unsigned W       = 8;
  localparam int unsigned N_UNITS = 5;
  localparam int unsigned REP_W   = 3;
  localparam int unsigned OP_W    = 3;

  localparam logic [OP_W-1:0] OP_NOR   = 3'd0;
  localparam logic [OP_W-1:0] OP_AND   = 3'd1;
  localparam logic [OP_W-1:0] OP_OR    = 3'd2;
  localparam logic [OP_W-1:0] OP_XOR   = 3'd3;
  localparam logic [OP_W-1:0] OP_NAND  = 3'd4;
  localparam logic [OP_W-1:0] OP_LOAD  = 3'd5;
  localparam logic [OP_W-1:0] OP_CLEAR = 3'd6;
  localparam logic [OP_W-1:0] OP_RSVD  = 3'd7;

  // Unit positions on the EN bus, shared with the unit instantiation
  localparam int unsigned U_NOR  = 0;
  localparam int unsigned U_AND  = 1;
  localparam int unsigned U_OR   = 2;
  localparam int unsigned U_XOR  = 3;
  localparam int unsigned U_NAND = 4;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_CAPTURE = 2'd2,
    S_FIN     = 2'd3
  } state_t;

endpackage

// File: rtl/alu_op_decoder.sv
// Maps an opcode plus an issue qualifier to one-hot unit enables and op-class flags.
module alu_op_decoder
  import alu_pkg::*;
(
  input  logic [OP_W-1:0]    i_op,
  input  logic               i_issue,
  output logic [N_UNITS-1:0] o_en_c,
  output logic               o_is_unit_c,
  output logic               o_is_load_c,
  output logic               o_is_clear_c
);

  logic [N_UNITS-1:0] w_onehot;

  assign o_is_unit_c  = (i_op <= OP_NAND);
  assign o_is_load_c  = (i_op == OP_LOAD);
  assign o_is_clear_c = (i_op == OP_CLEAR);
  assign w_onehot     = N_UNITS'(1) << i_op;
  assign o_en_c       = (i_issue && o_is_unit_c) ? w_onehot : '0;

endmodule

// File: rtl/alu_op_sequencer.sv
// Operand latch, unit-enable sequencer and stored-value accumulator for the bitwise units.
module alu_op_sequencer
  import alu_pkg::*;
(
  input  logic               CLK,
  input  logic               RST,
  input  logic [W-1:0]       DIN,
  input  logic [OP_W-1:0]    OP,
  input  logic [REP_W-1:0]   REP,
  input  logic               GO,
  input  logic [W-1:0]       RES,
  output logic [W-1:0]       IN,
  output logic [W-1:0]       SV,
  output logic [N_UNITS-1:0] EN,
  output logic               BUSY,
  output logic               DONE,
  output logic               ERR,
  output logic               ZERO
);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [OP_W-1:0]    r_op;
  logic [REP_W-1:0]   r_cnt;
  logic [W-1:0]       r_in;
  logic [W-1:0]       r_sv;
  logic [N_UNITS-1:0] r_en;
  logic               r_busy;
  logic               r_done;
  logic               r_err;

  logic               w_accept;
  logic [OP_W-1:0]    w_op_nxt;
  logic [REP_W-1:0]   w_cnt_nxt;
  logic [W-1:0]       w_in_nxt;
  logic [W-1:0]       w_sv_nxt;
  logic               w_err_nxt;
  logic               w_issue_nxt;
  logic [N_UNITS-1:0] w_en_nxt;
  logic               w_is_unit;
  logic               w_is_load;
  logic               w_is_clear;

  assign w_accept    = (r_state == S_IDLE) && GO;
  assign w_op_nxt    = w_accept ? OP : r_op;
  assign w_issue_nxt = (w_state_nxt == S_ISSUE) || (w_state_nxt == S_CAPTURE);

  // Decode the opcode that will be live in the next cycle so EN can be registered
  alu_op_decoder u_dec (
    .i_op         (w_op_nxt),
    .i_issue      (w_issue_nxt),
    .o_en_c       (w_en_nxt),
    .o_is_unit_c  (w_is_unit),
    .o_is_load_c  (w_is_load),
    .o_is_clear_c (w_is_clear)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (GO) w_state_nxt = w_is_unit ? S_ISSUE : S_FIN;
      S_ISSUE:   w_state_nxt = S_CAPTURE;
      S_CAPTURE: w_state_nxt = (r_cnt != '0) ? S_ISSUE : S_FIN;
      S_FIN:     w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_cnt_nxt = r_cnt;
    w_in_nxt  = r_in;
    w_sv_nxt  = r_sv;
    w_err_nxt = r_err;
    if (w_accept) begin
      w_in_nxt  = DIN;
      w_cnt_nxt = REP;
      w_err_nxt = 1'b0;
      if (w_is_load)       w_sv_nxt  = DIN;
      else if (w_is_clear) w_sv_nxt  = '0;
      else if (!w_is_unit) w_err_nxt = 1'b1;
    end else if (r_state == S_CAPTURE) begin
      w_sv_nxt = RES;
      if (r_cnt != '0) w_cnt_nxt = r_cnt - REP_W'(1);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_op   <= '0;
      r_cnt  <= '0;
      r_in   <= '0;
      r_sv   <= '0;
      r_en   <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      r_op   <= w_op_nxt;
      r_cnt  <= w_cnt_nxt;
      r_in   <= w_in_nxt;
      r_sv   <= w_sv_nxt;
      r_en   <= w_en_nxt;
      r_busy <= (w_state_nxt != S_IDLE);
      r_done <= (w_state_nxt == S_FIN);
      r_err  <= w_err_nxt;
    end
  end

  assign IN   = r_in;
  assign SV   = r_sv;
  assign EN   = r_en;
  assign BUSY = r_busy;
  assign DONE = r_done;
  assign ERR  = r_err;
  assign ZERO = (r_sv == '0);

  // EN is zero or one-hot, and only live during ISSUE/CAPTURE
  a_en_legal: assert property (@(posedge CLK) disable iff (RST)
    $onehot0(r_en) && ((r_en == '0) || (r_state == S_ISSUE) || (r_state == S_CAPTURE)));

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed table-driven bench for alu_op_sequencer with a behavioural model of the five bitwise units.
module tb_alu_op_sequencer;
  import alu_pkg::*;

  logic               CLK = 1'b0;
  logic               RST = 1'b1;
  logic [W-1:0]       DIN = '0;
  logic [OP_W-1:0]    OP  = '0;
  logic [REP_W-1:0]   REP = '0;
  logic               GO  = 1'b0;
  logic [W-1:0]       RES;
  logic [W-1:0]       IN;
  logic [W-1:0]       SV;
  logic [N_UNITS-1:0] EN;
  logic               BUSY;
  logic               DONE;
  logic               ERR;
  logic               ZERO;

  int n_vec = 0;
  int n_err = 0;

  alu_op_sequencer dut (
    .CLK(CLK), .RST(RST), .DIN(DIN), .OP(OP), .REP(REP), .GO(GO), .RES(RES),
    .IN(IN), .SV(SV), .EN(EN), .BUSY(BUSY), .DONE(DONE), .ERR(ERR), .ZERO(ZERO)
  );

  always #5 CLK = ~CLK;

  // Enable-gated bitwise units, OR-combined onto RES
  always_comb begin
    RES = '0;
    if (EN[U_NOR])  RES = RES | ~(IN | SV);
    if (EN[U_AND])  RES = RES |  (IN & SV);
    if (EN[U_OR])   RES = RES |  (IN | SV);
    if (EN[U_XOR])  RES = RES |  (IN ^ SV);
    if (EN[U_NAND]) RES = RES | ~(IN & SV);
  end

  typedef struct {
    string      name;
    logic [2:0] op;
    logic [7:0] din;
    logic [2:0] rep;
    logic [7:0] sv_init;
    logic [7:0] exp_sv;
    logic       exp_err;
    int         exp_lat;
    int         exp_en;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Issue one op; lat = edges after the GO edge until DONE is seen, en_cyc = cycles with EN set
  task automatic run_op(input logic [2:0] op, input logic [7:0] din, input logic [2:0] rep,
                        output int lat, output int en_cyc);
    @(negedge CLK);
    OP = op; DIN = din; REP = rep; GO = 1'b1;
    @(posedge CLK); #1;
    GO = 1'b0;
    lat = 1; en_cyc = 0;
    while (!DONE && lat < 40) begin
      if (EN != '0) en_cyc++;
      @(posedge CLK); #1;
      lat++;
    end
    check("done_seen", 32'(DONE), 32'd1);
    @(posedge CLK); #1;
  endtask

  vec_t vt[10];
  int   lat, en_cyc, dcnt;

  initial begin
    vt[0] = '{"load",    OP_LOAD,  8'hA5, 3'd0, 8'h00, 8'hA5, 1'b0, 1,  0};
    vt[1] = '{"nor",     OP_NOR,   8'h30, 3'd0, 8'h0F, 8'hC0, 1'b0, 3,  2};
    vt[2] = '{"xor_r2",  OP_XOR,   8'hFF, 3'd2, 8'h00, 8'hFF, 1'b0, 7,  6};
    vt[3] = '{"and",     OP_AND,   8'h3C, 3'd0, 8'hF0, 8'h30, 1'b0, 3,  2};
    vt[4] = '{"or_r3",   OP_OR,    8'h80, 3'd3, 8'h01, 8'h81, 1'b0, 9,  8};
    vt[5] = '{"nand_r1", OP_NAND,  8'h0F, 3'd1, 8'hFF, 8'hFF, 1'b0, 5,  4};
    vt[6] = '{"xor_r7",  OP_XOR,   8'h5A, 3'd7, 8'h00, 8'h00, 1'b0, 17, 16};
    vt[7] = '{"nor_r1",  OP_NOR,   8'h00, 3'd1, 8'h00, 8'h00, 1'b0, 5,  4};
    vt[8] = '{"clear",   OP_CLEAR, 8'hEE, 3'd5, 8'h77, 8'h00, 1'b0, 1,  0};
    vt[9] = '{"rsvd",    OP_RSVD,  8'hEE, 3'd0, 8'h3C, 8'h3C, 1'b1, 1,  0};

    repeat (2) @(posedge CLK);
    #1;
    check("rst_sv",   32'(SV),   32'h0);
    check("rst_in",   32'(IN),   32'h0);
    check("rst_en",   32'(EN),   32'h0);
    check("rst_busy", 32'(BUSY), 32'h0);
    check("rst_done", 32'(DONE), 32'h0);
    check("rst_err",  32'(ERR),  32'h0);
    check("rst_zero", 32'(ZERO), 32'h1);
    @(negedge CLK);
    RST = 1'b0;

    for (int i = 0; i < 10; i++) begin
      run_op(OP_LOAD, vt[i].sv_init, 3'd0, lat, en_cyc);
      run_op(vt[i].op, vt[i].din, vt[i].rep, lat, en_cyc);
      check({vt[i].name, "_sv"},   32'(SV),   32'(vt[i].exp_sv));
      check({vt[i].name, "_err"},  32'(ERR),  32'(vt[i].exp_err));
      check({vt[i].name, "_zero"}, 32'(ZERO), 32'(vt[i].exp_sv == 8'h00));
      check({vt[i].name, "_lat"},  32'(lat),  32'(vt[i].exp_lat));
      check({vt[i].name, "_en"},   32'(en_cyc), 32'(vt[i].exp_en));
      check({vt[i].name, "_busy"}, 32'(BUSY), 32'h0);
    end

    // Reserved opcode sets ERR; the next accepted CLEAR drops it
    run_op(OP_LOAD, 8'h3C, 3'd0, lat, en_cyc);
    run_op(OP_RSVD, 8'h11, 3'd0, lat, en_cyc);
    check("rsvd_err", 32'(ERR), 32'h1);
    check("rsvd_sv",  32'(SV),  32'h3C);
    run_op(OP_CLEAR, 8'h11, 3'd0, lat, en_cyc);
    check("clr_err",  32'(ERR),  32'h0);
    check("clr_sv",   32'(SV),   32'h0);
    check("clr_zero", 32'(ZERO), 32'h1);

    // GO with AND/DIN=0 mid-run of an OR must be ignored
    run_op(OP_LOAD, 8'h01, 3'd0, lat, en_cyc);
    @(negedge CLK);
    OP = OP_OR; DIN = 8'h80; REP = 3'd3; GO = 1'b1;
    @(posedge CLK); #1;
    GO = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    OP = OP_AND; DIN = 8'h00; REP = 3'd0; GO = 1'b1;
    @(posedge CLK); #1;
    GO = 1'b0;
    dcnt = 0;
    for (int c = 0; c < 20; c++) begin
      if (DONE) dcnt++;
      @(posedge CLK); #1;
    end
    check("lock_done", 32'(dcnt), 32'd1);
    check("lock_sv",   32'(SV),   32'h81);
    check("lock_in",   32'(IN),   32'h80);

    // GO held high re-triggers on the IDLE cycle after FIN
    @(negedge CLK);
    OP = OP_LOAD; DIN = 8'h12; REP = 3'd0; GO = 1'b1;
    dcnt = 0;
    for (int c = 0; c < 4; c++) begin
      @(posedge CLK); #1;
      if (DONE) dcnt++;
    end
    @(negedge CLK);
    GO = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(posedge CLK); #1;
      if (DONE) dcnt++;
    end
    check("hold_done", 32'(dcnt), 32'd2);
    check("hold_sv",   32'(SV),   32'h12);

    // Asynchronous reset in CAPTURE aborts without DONE
    run_op(OP_LOAD, 8'h55, 3'd0, lat, en_cyc);
    @(negedge CLK);
    OP = OP_NOR; DIN = 8'h0F; REP = 3'd2; GO = 1'b1;
    @(posedge CLK); #1;
    GO = 1'b0;
    @(posedge CLK); #1;
    check("abort_en_pre", 32'(EN), 32'h1);
    #2;
    RST = 1'b1;
    #1;
    check("abort_busy", 32'(BUSY), 32'h0);
    check("abort_en",   32'(EN),   32'h0);
    check("abort_sv",   32'(SV),   32'h0);
    check("abort_done", 32'(DONE), 32'h0);
    @(negedge CLK);
    RST = 1'b0;
    dcnt = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge CLK); #1;
      if (DONE) dcnt++;
    end
    check("abort_nodone", 32'(dcnt), 32'd0);
    run_op(OP_LOAD, 8'h99, 3'd0, lat, en_cyc);
    check("post_sv",  32'(SV),  32'h99);
    check("post_lat", 32'(lat), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
